// File: rtl/regfile_alu_seq.sv
// Operand-fetch/execute/write-back sequencer for regfile8x16c: accept -> write lands 3 edges later, one command per 4 cycles.
// cmd_ready is high only in IDLE. Defining ALU_FLAGS_EN adds the zf/cf/nf status outputs.
module regfile_alu_seq #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srcA,
  input  logic [AW-1:0] cmd_srcB,
  output logic [AW-1:0] rdAddrA,
  output logic [AW-1:0] rdAddrB,
  input  logic [DW-1:0] rdDataA,
  input  logic [DW-1:0] rdDataB,
  output logic          write,
  output logic [AW-1:0] wrAddr,
  output logic [DW-1:0] wrData,
  output logic          done
`ifdef ALU_FLAGS_EN
  ,
  output logic          zf,
  output logic          cf,
  output logic          nf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  state_t        state, state_nxt;
  logic          accept;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] opA, opB;
  logic [DW-1:0] result;
  logic [DW-1:0] alu_res;
  logic [3:0]    shamt;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign shamt     = opB[3:0];
  assign wrData    = result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = opA;
    case (op_q)
      OP_ADD:  alu_res = opA + opB;
      OP_SUB:  alu_res = opA - opB;
      OP_AND:  alu_res = opA & opB;
      OP_OR:   alu_res = opA | opB;
      OP_XOR:  alu_res = opA ^ opB;
      OP_SHL:  alu_res = opA << shamt;
      OP_SHR:  alu_res = opA >> shamt;
      default: alu_res = opA;
    endcase
  end

  // Read addresses are registered on the accept edge so the regfile
  // presents operand data throughout READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      dst_q   <= '0;
      rdAddrA <= '0;
      rdAddrB <= '0;
      opA     <= '0;
      opB     <= '0;
      result  <= '0;
      wrAddr  <= '0;
      write   <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        dst_q   <= cmd_dst;
        rdAddrA <= cmd_srcA;
        rdAddrB <= cmd_srcB;
      end
      if (state == READ) begin
        opA <= rdDataA;
        opB <= rdDataB;
      end
      if (state == EXEC) begin
        result <= alu_res;
        wrAddr <= dst_q;
      end
      write <= (state == EXEC);
      done  <= (state == EXEC);
    end
  end

`ifdef ALU_FLAGS_EN
  logic alu_cf;

  // Shift carry is the last bit pushed out; a zero shift amount leaves it 0.
  always_comb begin
    alu_cf = 1'b0;
    case (op_q)
      OP_ADD: alu_cf = (alu_res < opA);
      OP_SUB: alu_cf = (opA < opB);
      OP_SHL: begin
        for (int i = 1; i < 16; i++) begin
          if (shamt == 4'(i)) alu_cf = opA[DW-i];
        end
      end
      OP_SHR: begin
        for (int i = 1; i < 16; i++) begin
          if (shamt == 4'(i)) alu_cf = opA[i-1];
        end
      end
      default: alu_cf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf <= 1'b0;
      cf <= 1'b0;
      nf <= 1'b0;
    end else if (state == EXEC) begin
      zf <= (alu_res == '0);
      cf <= alu_cf;
      nf <= alu_res[DW-1];
    end
  end
`endif

endmodule
